// File: rtl/trade_recorder.sv
// trade_recorder
// Records every matched order pair as a trade {seq, price, spread}. Records
// are queued in a first-word-fall-through FIFO and drained through a
// valid/ready port. The block also keeps saturating trade statistics.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid           : order pair and comparison result valid this cycle
//   buy_price          : bid price (not stored; the trade executes at the ask)
//   sell_price         : ask price, recorded as the execution price
//   match_flag, spread : comparison result from the matching engine
//   stats_clr          : synchronous clear of statistics and overflow
//   out_ready          : consumer takes the head record
//   out_valid          : head record present
//   out_seq/price/spread : head record fields
//   fifo_level         : FIFO occupancy
//   trade_count, nomatch_count, drop_count : saturating event counters
//   spread_total       : saturating sum of accepted spreads
//   max_spread         : largest accepted spread
//   overflow           : sticky, set on the first drop
module trade_recorder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               buy_price,
    input  logic [7:0]               sell_price,
    input  logic                     match_flag,
    input  logic [7:0]               spread,
    input  logic                     stats_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_seq,
    output logic [7:0]               out_price,
    output logic [7:0]               out_spread,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         trade_count,
    output logic [CNT_W-1:0]         nomatch_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W+7:0]         spread_total,
    output logic [7:0]               max_spread,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [7:0]    seq_ctr;

    logic full;
    logic pop;
    logic accept;
    logic drop;
    logic nomatch;
    logic [CNT_W+8:0] spread_sum;

    // The trade executes at the ask, so the bid is not recorded.
    logic unused_buy;
    assign unused_buy = ^buy_price;

    assign full    = (count == FULL_LVL);
    assign pop     = out_valid && out_ready;
    // A full FIFO can still take a record when the head leaves in the same cycle.
    assign accept  = in_valid && match_flag && (!full || pop);
    assign drop    = in_valid && match_flag && full && !pop;
    assign nomatch = in_valid && !match_flag;

    // One extra bit catches the carry that signals saturation.
    assign spread_sum = {1'b0, spread_total} + {{(CNT_W+1){1'b0}}, spread};

    assign out_valid  = (count != '0);
    assign fifo_level = count;
    assign out_seq    = mem[rd_ptr][23:16];
    assign out_price  = mem[rd_ptr][15:8];
    assign out_spread = mem[rd_ptr][7:0];

    // Storage carries no reset; only entries behind the pointers are visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {seq_ctr, sell_price, spread};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            seq_ctr <= '0;
        end else begin
            if (accept) begin
                wr_ptr  <= wr_ptr + AW'(1);
                seq_ctr <= seq_ctr + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trade_count   <= '0;
            nomatch_count <= '0;
            drop_count    <= '0;
            spread_total  <= '0;
            max_spread    <= '0;
            overflow      <= 1'b0;
        end else if (stats_clr) begin
            trade_count   <= '0;
            nomatch_count <= '0;
            drop_count    <= '0;
            spread_total  <= '0;
            max_spread    <= '0;
            overflow      <= 1'b0;
        end else begin
            if (accept) begin
                if (trade_count != '1) begin
                    trade_count <= trade_count + CNT_W'(1);
                end
                if (spread_sum[CNT_W+8]) begin
                    spread_total <= '1;
                end else begin
                    spread_total <= spread_sum[CNT_W+7:0];
                end
                if (spread > max_spread) begin
                    max_spread <= spread;
                end
            end
            if (drop) begin
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
                overflow <= 1'b1;
            end
            if (nomatch && (nomatch_count != '1)) begin
                nomatch_count <= nomatch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trade_recorder.sv
module tb_trade_recorder;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        buy_price;
    logic [7:0]        sell_price;
    logic              match_flag;
    logic [7:0]        spread;
    logic              stats_clr;
    logic              out_ready;
    logic              out_valid;
    logic [7:0]        out_seq;
    logic [7:0]        out_price;
    logic [7:0]        out_spread;
    logic [3:0]        fifo_level;
    logic [CNT_W-1:0]  trade_count;
    logic [CNT_W-1:0]  nomatch_count;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W+7:0]  spread_total;
    logic [7:0]        max_spread;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    trade_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .buy_price     (buy_price),
        .sell_price    (sell_price),
        .match_flag    (match_flag),
        .spread        (spread),
        .stats_clr     (stats_clr),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_seq       (out_seq),
        .out_price     (out_price),
        .out_spread    (out_spread),
        .fifo_level    (fifo_level),
        .trade_count   (trade_count),
        .nomatch_count (nomatch_count),
        .drop_count    (drop_count),
        .spread_total  (spread_total),
        .max_spread    (max_spread),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic [7:0] s,
                         input logic m, input logic [7:0] sp);
        in_valid   = v;
        buy_price  = b;
        sell_price = s;
        match_flag = m;
        spread     = sp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        stats_clr = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_trade", 32'(trade_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Basic pairs: (100,90) match, (80,95) no match, (120,120) match.
        drive(1'b1, 8'd100, 8'd90, 1'b1, 8'd10);
        tick();
        check("basic_valid0", 32'(out_valid), 32'd1);
        check("basic_seq0", 32'(out_seq), 32'd0);
        check("basic_price0", 32'(out_price), 32'd90);
        check("basic_spread0", 32'(out_spread), 32'd10);
        drive(1'b1, 8'd80, 8'd95, 1'b0, 8'd15);
        tick();
        check("basic_level_after_pop", 32'(fifo_level), 32'd0);
        drive(1'b1, 8'd120, 8'd120, 1'b1, 8'd0);
        tick();
        check("basic_seq1", 32'(out_seq), 32'd1);
        check("basic_price1", 32'(out_price), 32'd120);
        check("basic_spread1", 32'(out_spread), 32'd0);
        check("basic_trade", 32'(trade_count), 32'd2);
        check("basic_nomatch", 32'(nomatch_count), 32'd1);
        check("basic_total", 32'(spread_total), 32'd10);
        check("basic_max", 32'(max_spread), 32'd10);
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        tick();
        check("basic_drained", 32'(out_valid), 32'd0);

        // Fill and overflow: 10 matches with spread k, no draining.
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 8'(60 + k), 8'(50 + k), 1'b1, 8'(k));
            tick();
        end
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_drop", 32'(drop_count), 32'd2);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_trade", 32'(trade_count), 32'd8);
        check("fill_max", 32'(max_spread), 32'd8);
        check("fill_total", 32'(spread_total), 32'd36);
        check("fill_head_seq", 32'(out_seq), 32'd0);
        check("fill_head_price", 32'(out_price), 32'd51);

        // Full with simultaneous pop and push.
        out_ready = 1'b1;
        drive(1'b1, 8'd90, 8'd77, 1'b1, 8'd5);
        tick();
        check("fullpop_level", 32'(fifo_level), 32'd8);
        check("fullpop_drop", 32'(drop_count), 32'd2);
        check("fullpop_trade", 32'(trade_count), 32'd9);
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            check("drain_seq", 32'(out_seq), 32'(i));
            check("drain_spread", 32'(out_spread), 32'(i + 1));
            check("drain_price", 32'(out_price), 32'(51 + i));
            tick();
        end
        check("drain_last_seq", 32'(out_seq), 32'd8);
        check("drain_last_price", 32'(out_price), 32'd77);
        check("drain_last_spread", 32'(out_spread), 32'd5);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Clear coincident with a match: stats zero, record still pushed.
        out_ready = 1'b0;
        stats_clr = 1'b1;
        drive(1'b1, 8'd70, 8'd60, 1'b1, 8'd7);
        tick();
        stats_clr = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        check("clr_trade", 32'(trade_count), 32'd0);
        check("clr_nomatch", 32'(nomatch_count), 32'd0);
        check("clr_drop", 32'(drop_count), 32'd0);
        check("clr_total", 32'(spread_total), 32'd0);
        check("clr_max", 32'(max_spread), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd1);
        check("clr_seq", 32'(out_seq), 32'd9);
        check("clr_spread", 32'(out_spread), 32'd7);
        drive(1'b1, 8'd70, 8'd61, 1'b1, 8'd9);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        check("postclr_trade", 32'(trade_count), 32'd1);
        check("postclr_level", 32'(fifo_level), 32'd2);
        check("postclr_head_stable", 32'(out_seq), 32'd9);
        out_ready = 1'b1;
        tick();
        check("postclr_seq10", 32'(out_seq), 32'd10);
        tick();

        // Saturation and sequence wrap: 300 matches with spread 255.
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 8'd255, 8'd0, 1'b1, 8'd255);
            tick();
            check("sat_seq", 32'(out_seq), 32'((i - 1) % 256));
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        check("sat_trade", 32'(trade_count), 32'd255);
        check("sat_total", 32'(spread_total), 32'd65535);
        check("sat_max", 32'(max_spread), 32'd255);
        check("sat_level", 32'(fifo_level), 32'd1);
        tick();

        // Asynchronous reset mid-cycle with 5 queued records.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd40, 8'(30 + i), 1'b1, 8'd10);
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        check("areset_pre_level", 32'(fifo_level), 32'd5);
        check("areset_pre_trade", 32'(trade_count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_level", 32'(fifo_level), 32'd0);
        check("areset_trade", 32'(trade_count), 32'd0);
        check("areset_total", 32'(spread_total), 32'd0);
        check("areset_max", 32'(max_spread), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'd50, 8'd44, 1'b1, 8'd6);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        check("areset_first_seq", 32'(out_seq), 32'd0);
        check("areset_first_price", 32'(out_price), 32'd44);
        check("areset_first_level", 32'(fifo_level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trade_recorder.md
# trade_recorder

Downstream stage of `matching_engine`. Samples each priced order pair together with its `match_flag`/`spread` result and turns every match into a trade record. Records go into a small first-word-fall-through (FWFT) FIFO drained through a valid/ready port. The block also keeps saturating trade statistics for the status/display logic.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `CNT_W`, 16: width of trade, no-match and drop counters.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the order pair and comparison result below are valid this cycle.
- `buy_price` input 8: bid price of the pair.
- `sell_price` input 8: ask price of the pair.
- `match_flag` input 1: 1 when buy ≥ sell.
- `spread` input 8: |buy − sell|.
- `stats_clr` input 1: synchronous clear of statistics; does not touch the FIFO.
- `out_ready` input 1: consumer accepts the head record this cycle.
- `out_valid` output 1: head record present (FIFO not empty).
- `out_seq` output 8: sequence number of the head record.
- `out_price` output 8: execution price of the head record (= `sell_price`).
- `out_spread` output 8: spread of the head record.
- `fifo_level` output log2(DEPTH)+1: current occupancy.
- `trade_count` output CNT_W: accepted trades, saturating.
- `nomatch_count` output CNT_W: valid pairs with no match, saturating.
- `drop_count` output CNT_W: matches lost because the FIFO was full, saturating.
- `spread_total` output CNT_W+8: sum of accepted spreads, saturating.
- `max_spread` output 8: largest accepted spread.
- `overflow` output 1: sticky; set on the first drop.

## Operation
- Ignore every input except `stats_clr` when `in_valid`=0.
- **Pop:** happens when `out_valid`=1 and `out_ready`=1.
- **Accept:** happens when `in_valid`=1, `match_flag`=1, and the FIFO is either not full or is being popped in the same cycle.
  - Push record {`seq_ctr`, `sell_price`, `spread`}.
  - Increment `seq_ctr`; it is 8 bits and wraps 255→0.
  - Increment `trade_count`.
  - Add `spread` to `spread_total`.
  - Set `max_spread` = max(`max_spread`, `spread`).
- **Drop:** happens when `in_valid`=1, `match_flag`=1, the FIFO is full, and no pop occurs.
  - Write nothing.
  - `seq_ctr` is unchanged.
  - Increment `drop_count`.
  - Set `overflow`=1.
- **No match:** `in_valid`=1 and `match_flag`=0 increments `nomatch_count`.
- **Saturation:** all counters and `spread_total` hold at all-ones, never wrap.
- **Statistics clear:** `stats_clr`=1 zeroes `trade_count`, `nomatch_count`, `drop_count`, `spread_total`, `max_spread` and `overflow`.
  - Clear wins over a same-cycle statistics update.
  - A same-cycle push or pop still occurs.
  - `seq_ctr` and FIFO contents are untouched.
- **FIFO structure:** circular buffer with read/write pointers and an explicit count.
  - `fifo_level` = count.
  - `out_*` come combinationally from the head entry.
  - `out_*` are don't-care while `out_valid`=0.
- The block does not check `match_flag`/`spread` against the prices; upstream is trusted.

## Timing
- **Reset:** asynchronous assertion clears:
  - pointers, count and `seq_ctr`;
  - all statistics and `overflow`;
  - `out_valid` (to 0).
  - FIFO storage needs no reset.
- **Push latency:** an accepted pair at edge N gives `out_valid`=1 and the new record at the head after edge N, when the FIFO was empty.
- **Statistics latency:** statistics reflect edge N's event after edge N (1-cycle latency).
- **Simultaneous pop and push:**
  - When full, occupancy stays at DEPTH and there is no drop.
  - When empty, no pop is possible (`out_valid`=0), so the push alone lands.
- **Reset mid-operation:** discards all queued records; the first post-reset record has `out_seq`=0.
- **Back-pressure:** `out_ready` may be held low indefinitely. Head data stays stable while `out_valid`=1 and no pop occurs.

## Test plan
- **Reset state:** after reset, apply pairs (100,90), (80,95), (120,120), all `in_valid`=1, `out_ready`=1.
  - 2 records: seq 0 price 90 spread 10, then seq 1 price 120 spread 0.
  - `trade_count`=2, `nomatch_count`=1, `spread_total`=10, `max_spread`=10.
- **Fill and overflow:** `out_ready`=0; apply 10 matches with spread=k (k=1..10), DEPTH=8.
  - `fifo_level`=8, `drop_count`=2, `overflow`=1, `trade_count`=8, `max_spread`=8.
  - Draining yields seq 0..7.
- **Full with pop:** FIFO full, `out_ready`=1 plus a match (spread 5) in the same cycle.
  - No drop; level stays 8.
  - Appended record carries the next sequence number.
- **Saturation and wrap:** 300 matches with spread 255, `out_ready`=1.
  - `out_seq` wraps 255→0.
  - With CNT_W=8: `trade_count`=255, `spread_total`=65535, both saturated.
- **Clear:** `stats_clr` coincident with a match (spread 7).
  - All statistics read 0 the next cycle.
  - The record is still pushed and `seq_ctr` advances.
- **Async reset:** assert `rst` mid-cycle with 5 queued records.
  - `out_valid`, `fifo_level` and statistics go to 0 immediately, without waiting for an edge.
